// File: rtl/fft_input_loader_pkg.sv
// Shared FFT definitions: frame geometry, RAM A banking and loader state encoding.
// fft_control imports the same package, so both blocks agree on the layout.
package fft_input_loader_pkg;

    localparam int unsigned FFT_N_PT       = 2048;
    localparam int unsigned FFT_BANKS      = 4;
    localparam int unsigned FFT_BANK_DEPTH = 512;
    localparam int unsigned FFT_CNT_W      = $clog2(FFT_N_PT);
    localparam int unsigned FFT_ADDR_W     = $clog2(FFT_BANK_DEPTH);
    localparam int unsigned FFT_BANK_W     = $clog2(FFT_BANKS);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_KICK    = 3'd2;
    localparam logic [2:0] ST_WAIT_LO = 3'd3;
    localparam logic [2:0] ST_WAIT_HI = 3'd4;

    function automatic logic [FFT_BANKS-1:0] bank_onehot(input logic [FFT_BANK_W-1:0] bank);
        return FFT_BANKS'(1) << bank;
    endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Sample stream, RAM A write port and fft_control handshake of the input loader.
interface fft_input_loader_if #(
    parameter int DATA_W = 16
);

    logic [DATA_W-1:0]                                  iDATA_RE;
    logic [DATA_W-1:0]                                  iDATA_IM;
    logic                                               iVALID;
    logic                                               iSOP;
    logic                                               oREADY;
    logic [fft_input_loader_pkg::FFT_BANKS-1:0]         oWE;
    logic [fft_input_loader_pkg::FFT_ADDR_W-1:0]        oADDR_WR;
    logic [DATA_W-1:0]                                  oDATA_RE;
    logic [DATA_W-1:0]                                  oDATA_IM;
    logic                                               iFFT_RDY;
    logic                                               oSTART;
    logic                                               oFRAME_ERR;
    logic                                               oBUSY;

    modport master (
        output iDATA_RE, iDATA_IM, iVALID, iSOP, iFFT_RDY,
        input  oREADY, oWE, oADDR_WR, oDATA_RE, oDATA_IM, oSTART, oFRAME_ERR, oBUSY
    );

    modport slave (
        input  iDATA_RE, iDATA_IM, iVALID, iSOP, iFFT_RDY,
        output oREADY, oWE, oADDR_WR, oDATA_RE, oDATA_IM, oSTART, oFRAME_ERR, oBUSY
    );

endinterface

// File: rtl/fft_input_loader.sv
// Loads one FFT frame of complex samples into the four RAM A banks, then kicks
// fft_control and waits for the transform to finish before accepting a new frame.
module fft_input_loader
    import fft_input_loader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_PT   = FFT_N_PT
) (
    input  logic              iCLK,
    input  logic              iRESET,
    fft_input_loader_if.slave bus
);

    logic [2:0]             r_state;
    logic [FFT_CNT_W-1:0]   r_cnt;
    logic [FFT_BANKS-1:0]   r_we;
    logic [FFT_ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]      r_data_re;
    logic [DATA_W-1:0]      r_data_im;
    logic                   r_start;
    logic                   r_frame_err;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_write;
    logic                   w_last;
    logic [FFT_CNT_W-1:0]   w_wr_idx;

    always_comb begin
        // Ready is gated by iFFT_RDY in every state so RAM A is untouched mid-transform.
        w_ready  = !iRESET && bus.iFFT_RDY && (r_state == ST_IDLE || r_state == ST_LOAD);
        w_accept = bus.iVALID && w_ready;
        w_write  = w_accept && (r_state == ST_LOAD || bus.iSOP);
        w_wr_idx = bus.iSOP ? '0 : r_cnt;
        w_last   = (r_state == ST_LOAD) && w_accept && !bus.iSOP
                   && (r_cnt == FFT_CNT_W'(N_PT - 1));
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= '0;
            r_addr      <= '0;
            r_data_re   <= '0;
            r_data_im   <= '0;
            r_start     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_we        <= w_write ? bank_onehot(w_wr_idx[FFT_CNT_W-1 -: FFT_BANK_W]) : '0;
            r_start     <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_write) begin
                r_addr    <= w_wr_idx[FFT_ADDR_W-1:0];
                r_data_re <= bus.iDATA_RE;
                r_data_im <= bus.iDATA_IM;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_write) begin
                        r_cnt   <= FFT_CNT_W'(1);
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (bus.iSOP) begin
                            // Resync: this sample becomes n=0 of a fresh frame.
                            r_cnt       <= FFT_CNT_W'(1);
                            r_frame_err <= (r_cnt != '0);
                        end else if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_KICK;
                        end else begin
                            r_cnt <= r_cnt + FFT_CNT_W'(1);
                        end
                    end
                end
                ST_KICK: begin
                    r_start <= 1'b1;
                    r_state <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (!bus.iFFT_RDY) begin
                        r_state <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (bus.iFFT_RDY) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.oREADY     = w_ready;
    assign bus.oWE        = r_we;
    assign bus.oADDR_WR   = r_addr;
    assign bus.oDATA_RE   = r_data_re;
    assign bus.oDATA_IM   = r_data_im;
    assign bus.oSTART     = r_start;
    assign bus.oFRAME_ERR = r_frame_err;
    assign bus.oBUSY      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader: random frames are compared against a
// frame-level model of RAM A contents, pulse counts and handshake timing.
module tb_fft_input_loader;

    localparam int DW = 16;
    localparam int NP = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_input_loader_if #(.DATA_W(DW)) bus ();

    fft_input_loader #(.DATA_W(DW), .N_PT(NP)) dut (
        .iCLK   (clk),
        .iRESET (rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference frame and captured RAM A image (flat index = bank*512 + addr).
    logic [DW-1:0] fr_re [NP];
    logic [DW-1:0] fr_im [NP];
    logic [DW-1:0] cap_re[NP];
    logic [DW-1:0] cap_im[NP];
    int            cap_cyc[NP];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int we_cnt = 0, we_bad = 0, start_cnt = 0, start_cyc = 0;
    int ferr_cnt = 0, ferr_cyc = 0, rdy_viol = 0;

    always @(negedge clk) begin : monitor
        int idx;
        if (bus.oWE != '0) begin
            we_cnt++;
            if (!$onehot(bus.oWE)) we_bad++;
            for (int b = 0; b < 4; b++) begin
                if (bus.oWE[b]) begin
                    idx = b * 512 + int'(bus.oADDR_WR);
                    cap_re[idx]  = bus.oDATA_RE;
                    cap_im[idx]  = bus.oDATA_IM;
                    cap_cyc[idx] = cyc;
                end
            end
        end
        if (bus.oSTART) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (bus.oFRAME_ERR) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
        if (!bus.iFFT_RDY && bus.oREADY) rdy_viol++;
    end

    int last_acc  = 0;
    int first_acc = 0;

    task automatic fill_frame(input bit ramp);
        for (int n = 0; n < NP; n++) begin
            fr_re[n] = ramp ? DW'(n)  : DW'($urandom);
            fr_im[n] = ramp ? DW'(-n) : DW'($urandom);
        end
    endtask

    // Sends samples 0..count-1 of the reference frame, iSOP on sample 0.
    task automatic send(input int count, input int duty);
        bit done;
        for (int n = 0; n < count; n++) begin
            done = 1'b0;
            for (int t = 0; t < 200 && !done; t++) begin
                @(posedge clk); #1;
                bus.iVALID   = ($urandom_range(99) < duty);
                bus.iSOP     = bus.iVALID ? (n == 0) : 1'($urandom_range(1));
                bus.iDATA_RE = bus.iVALID ? fr_re[n] : DW'($urandom);
                bus.iDATA_IM = bus.iVALID ? fr_im[n] : DW'($urandom);
                @(negedge clk);
                if (bus.iVALID) begin
                    check_eq("ready_load", bus.oREADY, 1);
                    last_acc = cyc;
                    if (n == 0) first_acc = cyc;
                    done = 1'b1;
                end
            end
            check_eq("send_progress", done, 1);
        end
        @(posedge clk); #1;
        bus.iVALID = 1'b0;
        bus.iSOP   = 1'b0;
    endtask

    task automatic verify_ram(input string tag, input int t0);
        int bad = 0;
        for (int n = 0; n < NP; n++)
            if (cap_cyc[n] < t0 || cap_re[n] !== fr_re[n] || cap_im[n] !== fr_im[n]) bad++;
        check_eq(tag, bad, 0);
    endtask

    // Waits for the kick, then plays fft_control: busy (iFFT_RDY low) for k_low cycles.
    task automatic kick_and_transform(input int s0, input int k_low);
        int w0, v0;
        for (int t = 0; t < 20 && start_cnt == s0; t++) @(posedge clk);
        check_eq("start_seen", start_cnt - s0, 1);
        check_eq("start_latency", start_cyc - last_acc, 2);
        @(negedge clk);
        @(negedge clk);
        check_eq("start_single", start_cnt - s0, 1);
        check_eq("ready_wait_lo", bus.oREADY, 0);
        check_eq("busy_wait_lo", bus.oBUSY, 1);
        @(posedge clk); #1;
        bus.iFFT_RDY = 1'b0;
        bus.iVALID   = 1'b1;
        bus.iSOP     = 1'b1;
        w0 = we_cnt;
        v0 = rdy_viol;
        repeat (k_low) @(negedge clk);
        check_eq("we_during_fft", we_cnt - w0, 0);
        check_eq("ready_during_fft", rdy_viol - v0, 0);
        @(posedge clk); #1;
        bus.iFFT_RDY = 1'b1;
        bus.iVALID   = 1'b0;
        bus.iSOP     = 1'b0;
        @(negedge clk);
        check_eq("ready_wait_hi", bus.oREADY, 0);
        @(negedge clk);
        check_eq("ready_idle_again", bus.oREADY, 1);
        check_eq("busy_idle_again", bus.oBUSY, 0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s0, w0, f0, t0;
        bus.iFFT_RDY = 1'b1;
        bus.iVALID   = 1'b1;
        bus.iSOP     = 1'b1;
        bus.iDATA_RE = DW'($urandom);
        bus.iDATA_IM = DW'($urandom);

        // Reset with a valid SOP presented: nothing may be accepted or written.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", bus.oREADY, 0);
        check_eq("rst_we", bus.oWE, 0);
        check_eq("rst_addr", bus.oADDR_WR, 0);
        check_eq("rst_re", bus.oDATA_RE, 0);
        check_eq("rst_im", bus.oDATA_IM, 0);
        check_eq("rst_start", bus.oSTART, 0);
        check_eq("rst_ferr", bus.oFRAME_ERR, 0);
        check_eq("rst_busy", bus.oBUSY, 0);
        @(posedge clk); #1;
        rst        = 1'b0;
        bus.iVALID = 1'b0;
        bus.iSOP   = 1'b0;

        // Samples without SOP in IDLE are dropped.
        w0 = we_cnt;
        repeat (20) begin
            @(posedge clk); #1;
            bus.iVALID   = 1'b1;
            bus.iDATA_RE = DW'($urandom);
            bus.iDATA_IM = DW'($urandom);
        end
        @(negedge clk);
        check_eq("idle_ready", bus.oREADY, 1);
        @(posedge clk); #1;
        bus.iVALID = 1'b0;
        @(negedge clk);
        check_eq("idle_no_we", we_cnt - w0, 0);
        check_eq("idle_busy", bus.oBUSY, 0);

        // Ramp frame, continuous valid.
        fill_frame(1'b1);
        s0 = start_cnt; w0 = we_cnt; t0 = cyc;
        send(NP, 100);
        kick_and_transform(s0, 5);
        check_eq("ramp_we_count", we_cnt - w0, NP);
        verify_ram("ramp_ram", t0);
        check_eq("ramp_b0a511_re", cap_re[511], 511);
        check_eq("ramp_b3a511_re", cap_re[2047], 2047);
        check_eq("ramp_b3a511_im", cap_im[2047], 16'hF801);

        // Random frame, 50% valid duty, long transform.
        fill_frame(1'b0);
        s0 = start_cnt; w0 = we_cnt; t0 = cyc;
        send(NP, 50);
        kick_and_transform(s0, 2600);
        check_eq("duty_we_count", we_cnt - w0, NP);
        verify_ram("duty_ram", t0);

        // SOP reasserted at n=700 resynchronises the frame.
        fill_frame(1'b0);
        s0 = start_cnt; w0 = we_cnt; f0 = ferr_cnt;
        send(700, 100);
        fill_frame(1'b0);
        t0 = cyc;
        send(NP, 80);
        kick_and_transform(s0, 10);
        check_eq("resync_ferr_count", ferr_cnt - f0, 1);
        check_eq("resync_ferr_latency", ferr_cyc - first_acc, 1);
        check_eq("resync_we_count", we_cnt - w0, 700 + NP);
        check_eq("resync_b0a0_re", cap_re[0], fr_re[0]);
        verify_ram("resync_ram", t0);

        // Reset at n=1000 discards the partial frame.
        fill_frame(1'b0);
        s0 = start_cnt; w0 = we_cnt;
        send(1000, 100);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_ready", bus.oREADY, 0);
        @(negedge clk);
        check_eq("midrst_we", bus.oWE, 0);
        check_eq("midrst_addr", bus.oADDR_WR, 0);
        check_eq("midrst_re", bus.oDATA_RE, 0);
        check_eq("midrst_im", bus.oDATA_IM, 0);
        check_eq("midrst_start", bus.oSTART, 0);
        check_eq("midrst_ferr", bus.oFRAME_ERR, 0);
        check_eq("midrst_busy", bus.oBUSY, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("midrst_no_start", start_cnt - s0, 0);
        check_eq("midrst_we_count", we_cnt - w0, 1000);
        fill_frame(1'b0);
        s0 = start_cnt; w0 = we_cnt; t0 = cyc;
        send(NP, 70);
        kick_and_transform(s0, 8);
        check_eq("postrst_we_count", we_cnt - w0, NP);
        verify_ram("postrst_ram", t0);

        check_eq("we_onehot", we_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
